// File: rtl/cpu_pkg.sv
`default_nettype none
// ==========================================================================
// cpu_pkg : shared pipeline types and widths for the CPU datapath
// Revision: 1.0
// ==========================================================================
package cpu_pkg;

  localparam int DATA_W     = 64;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 8;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ==========================================================================
// mem_wait_timer : saturating data-memory wait counter with timeout flag
// Revision: 1.0
// ==========================================================================
module mem_wait_timer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick && (count_q != LIMIT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires in the cycle whose missed ack makes the count reach the limit.
  assign expire = tick && (count_d == LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ==========================================================================
// mem_wb_stage : MEM stage data-memory handshake FSM and MEM/WB register
// Revision: 1.0
// ==========================================================================
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     address_MEM,
  input  logic [DATA_W-1:0]     Rd2_Reg_out_MEM,
  input  logic [DATA_W-1:0]     Add_offset_MEM,
  input  logic [DATA_W-1:0]     Add_4_MEM,
  input  logic                  RegWrite_MEM,
  input  logic                  MemtoReg_MEM,
  input  logic                  MemRead_MEM,
  input  logic                  MemWrite_MEM,
  input  logic                  Add2Reg_MEM,
  input  logic [REG_ADDR_W-1:0] Rd_MEM,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  stall_MEM,
  output logic                  fault_MEM,
  output logic [DATA_W-1:0]     wb_data_WB,
  output logic [REG_ADDR_W-1:0] Rd_WB,
  output logic                  RegWrite_WB
);

  mem_state_t state_q, state_d;

  logic                  dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0]     dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]     dmem_wdata_q, dmem_wdata_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  regwrite_q, regwrite_d;

  logic mem_op;
  logic stall;
  logic timer_clear;
  logic timer_tick;
  logic timer_expire;
  logic unused_branch_target;

  // The branch target is resolved upstream; this stage only passes PC+4.
  assign unused_branch_target = ^Add_offset_MEM;

  assign mem_op = MemRead_MEM | MemWrite_MEM;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .tick   (timer_tick),
    .expire (timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    timer_clear  = 1'b0;
    timer_tick   = 1'b0;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall        = 1'b1;
          timer_clear  = 1'b1;
          dmem_addr_d  = address_MEM;
          dmem_wdata_d = Rd2_Reg_out_MEM;
          dmem_we_d    = MemWrite_MEM;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_d = IDLE;
        end else begin
          stall      = 1'b1;
          timer_tick = 1'b1;
          if (timer_expire) begin
            state_d = FAULT;
          end
        end
      end
      FAULT: begin
        stall = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (reset) begin
      stall = 1'b0;
    end
  end

  // WB register load/bubble mux; a memory result only exists on the ack cycle.
  always_comb begin
    wb_data_d  = '0;
    rd_d       = ZERO_REG;
    regwrite_d = 1'b0;
    if (!stall) begin
      regwrite_d = RegWrite_MEM;
      rd_d       = Rd_MEM;
      if (state_q == WAIT) begin
        wb_data_d = (MemtoReg_MEM && !dmem_we_q) ? dmem_rdata : address_MEM;
      end else begin
        wb_data_d = Add2Reg_MEM ? Add_4_MEM : address_MEM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      wb_data_q    <= '0;
      rd_q         <= ZERO_REG;
      regwrite_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      wb_data_q    <= wb_data_d;
      rd_q         <= rd_d;
      regwrite_q   <= regwrite_d;
    end
  end

  assign dmem_req    = (state_q == WAIT);
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign stall_MEM   = stall;
  assign fault_MEM   = (state_q == FAULT);
  assign wb_data_WB  = wb_data_q;
  assign Rd_WB       = rd_q;
  assign RegWrite_WB = regwrite_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ==========================================================================
// tb_mem_wb_stage : randomized transaction-level bench for mem_wb_stage
// Revision: 1.0
// ==========================================================================
module tb_mem_wb_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] address_MEM, Rd2_Reg_out_MEM, Add_offset_MEM, Add_4_MEM;
  logic        RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, MemWrite_MEM, Add2Reg_MEM;
  logic [4:0]  Rd_MEM;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        stall_MEM, fault_MEM;
  logic [63:0] wb_data_WB;
  logic [4:0]  Rd_WB;
  logic        RegWrite_WB;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .address_MEM     (address_MEM),
    .Rd2_Reg_out_MEM (Rd2_Reg_out_MEM),
    .Add_offset_MEM  (Add_offset_MEM),
    .Add_4_MEM       (Add_4_MEM),
    .RegWrite_MEM    (RegWrite_MEM),
    .MemtoReg_MEM    (MemtoReg_MEM),
    .MemRead_MEM     (MemRead_MEM),
    .MemWrite_MEM    (MemWrite_MEM),
    .Add2Reg_MEM     (Add2Reg_MEM),
    .Rd_MEM          (Rd_MEM),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_ack        (dmem_ack),
    .dmem_rdata      (dmem_rdata),
    .stall_MEM       (stall_MEM),
    .fault_MEM       (fault_MEM),
    .wb_data_WB      (wb_data_WB),
    .Rd_WB           (Rd_WB),
    .RegWrite_WB     (RegWrite_WB)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_zero();
    address_MEM = '0; Rd2_Reg_out_MEM = '0; Add_offset_MEM = '0; Add_4_MEM = '0;
    RegWrite_MEM = 0; MemtoReg_MEM = 0; MemRead_MEM = 0; MemWrite_MEM = 0;
    Add2Reg_MEM = 0; Rd_MEM = '0; dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_wbdata"}, wb_data_WB, 64'd0);
    check({tag, "_rd"}, Rd_WB, 64'd31);
    check({tag, "_regwr"}, RegWrite_WB, 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_bubble(tag);
    check({tag, "_req"}, dmem_req, 0);
    check({tag, "_we"}, dmem_we, 0);
    check({tag, "_addr"}, dmem_addr, 0);
    check({tag, "_wdata"}, dmem_wdata, 0);
    check({tag, "_fault"}, fault_MEM, 0);
    check({tag, "_stall"}, stall_MEM, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_zero();
    #1;
    check("rst_stall_during", stall_MEM, 0);
    step();
    reset = 1'b0;
    #1;
    check_reset_vals("rst");
  endtask

  // Non-memory instruction: one cycle through, never stalls.
  task automatic alu_op(input logic a2r, input logic rw, input logic [4:0] rd,
                        input logic [63:0] addr, input logic [63:0] add4, input logic stray_ack);
    MemRead_MEM = 0; MemWrite_MEM = 0; MemtoReg_MEM = 1'($urandom);
    Add2Reg_MEM = a2r; RegWrite_MEM = rw; Rd_MEM = rd;
    address_MEM = addr; Add_4_MEM = add4;
    Add_offset_MEM = {$urandom, $urandom}; Rd2_Reg_out_MEM = {$urandom, $urandom};
    dmem_ack = stray_ack; dmem_rdata = {$urandom, $urandom};
    #1;
    check("alu_stall", stall_MEM, 0);
    check("alu_req", dmem_req, 0);
    step();
    dmem_ack = 0;
    check("alu_wbdata", wb_data_WB, a2r ? add4 : addr);
    check("alu_rd", Rd_WB, rd);
    check("alu_regwr", RegWrite_WB, rw);
    check("alu_fault", fault_MEM, 0);
  endtask

  // Memory instruction acked on WAIT cycle k; k > TO means no ack ever arrives.
  task automatic mem_op(input logic rd_en, input logic wr_en, input logic mtr, input logic rw,
                        input logic [4:0] rd, input logic [63:0] addr, input logic [63:0] sd,
                        input int k, input logic [63:0] rdata);
    logic [63:0] exp_wb;
    exp_wb = (mtr && !wr_en) ? rdata : addr;
    MemRead_MEM = rd_en; MemWrite_MEM = wr_en; MemtoReg_MEM = mtr;
    RegWrite_MEM = rw; Rd_MEM = rd; address_MEM = addr; Rd2_Reg_out_MEM = sd;
    Add2Reg_MEM = 1'($urandom); Add_4_MEM = {$urandom, $urandom};
    dmem_ack = 0;
    #1;
    check("mem_idle_stall", stall_MEM, 1);
    check("mem_idle_req", dmem_req, 0);
    step();
    for (int c = 1; c <= TO; c++) begin
      check("mem_wait_req", dmem_req, 1);
      check("mem_wait_addr", dmem_addr, addr);
      check("mem_wait_wdata", dmem_wdata, sd);
      check("mem_wait_we", dmem_we, wr_en);
      check_bubble("mem_wait");
      if (c == k) begin
        dmem_ack = 1; dmem_rdata = rdata;
        #1;
        check("mem_ack_stall", stall_MEM, 0);
        step();
        dmem_ack = 0;
        check("mem_wbdata", wb_data_WB, exp_wb);
        check("mem_rd", Rd_WB, rd);
        check("mem_regwr", RegWrite_WB, rw);
        check("mem_fault", fault_MEM, 0);
        check("mem_done_req", dmem_req, 0);
        return;
      end
      dmem_ack = 0; dmem_rdata = {$urandom, $urandom};
      #1;
      check("mem_wait_stall", stall_MEM, 1);
      step();
    end
    check("to_fault", fault_MEM, 1);
    check("to_req", dmem_req, 0);
    check("to_stall", stall_MEM, 1);
    check_bubble("to");
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    check("to_sticky", fault_MEM, 1);
    check("to_sticky_stall", stall_MEM, 1);
    check_bubble("to_sticky");
    do_reset();
  endtask

  task automatic reset_in_wait();
    MemRead_MEM = 1; MemWrite_MEM = 0; MemtoReg_MEM = 1; RegWrite_MEM = 1;
    Rd_MEM = 5'd7; address_MEM = 64'h200; dmem_ack = 0;
    step();
    step();
    check("rw_wait2_req", dmem_req, 1);
    reset = 1'b1;
    #1;
    check("rw_stall_in_reset", stall_MEM, 0);
    step();
    reset = 1'b0;
    drive_zero();
    dmem_ack = 1; dmem_rdata = 64'hBAD;
    #1;
    check_reset_vals("rw");
    step();
    dmem_ack = 0;
    check("rw_stray_regwr", RegWrite_WB, 0);
    check("rw_stray_wbdata", wb_data_WB, 0);
    check("rw_stray_stall", stall_MEM, 0);
    check("rw_stray_req", dmem_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive_zero();
    do_reset();

    alu_op(1'b0, 1'b1, 5'd3, 64'h1234, 64'h0, 1'b0);
    mem_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 64'h40, 64'h0, 4, 64'hDEAD);
    mem_op(1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 64'h80, 64'h55, 2, 64'hFFFF);
    mem_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 64'h100, 64'h0, TO + 1, 64'h0);
    mem_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 64'h108, 64'h0, TO, 64'hCAFE);
    mem_op(1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 64'h110, 64'h0, 1, 64'h77);
    reset_in_wait();
    alu_op(1'b1, 1'b1, 5'd10, 64'h9999, 64'h1004, 1'b1);

    for (int i = 0; i < 80; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        alu_op(1'($urandom), 1'($urandom), 5'($urandom), {$urandom, $urandom},
               {$urandom, $urandom}, 1'($urandom));
      end else begin
        logic r, w;
        r = 1'($urandom);
        w = r ? 1'($urandom) : 1'b1;
        mem_op(r, w, 1'($urandom), 1'($urandom), 5'($urandom), {$urandom, $urandom},
               {$urandom, $urandom}, $urandom_range(1, TO + 2), {$urandom, $urandom});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
